mem_access_ctrl: RTL and testbench

//  MEM-stage data-memory access controller; sits downstream of the EX/MEM pipeline register.

---
 rtl/mem_access_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : MEM-stage data-memory access controller with MEM/WB register.
//             Issues req/ack bus transactions and stalls the pipeline meanwhile.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        regWrite,
  input  logic [1:0]  memToReg,
  input  logic [31:0] aluResult,
  input  logic [31:0] readData2,
  input  logic [4:0]  writeDataReg,
  input  logic [29:0] fourPC,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_regWrite,
  output logic [1:0]  out_memToReg,
  output logic [4:0]  out_writeDataReg,
  output logic [31:0] out_aluResult,
  output logic [31:0] out_memData,
  output logic [29:0] out_fourPC,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [8:0] c_timeout = 9'(TIMEOUT_CYCLES);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        fault_q;
  logic [31:0] rdata_q;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        wb_regWrite_q;
  logic [1:0]  wb_memToReg_q;
  logic [4:0]  wb_writeDataReg_q;
  logic [31:0] wb_aluResult_q;
  logic [31:0] wb_memData_q;
  logic [29:0] wb_fourPC_q;
  logic        err_q;

  logic        w_access;
  logic        w_aligned;
  logic [8:0]  w_cnt_inc;
  logic        w_timeout;

  assign w_access  = memRead | memWrite;
  assign w_aligned = (aluResult[1:0] == 2'b00);
  // Post-increment count equals the number of BUSY cycles spent so far.
  assign w_cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign w_timeout = (w_cnt_inc == c_timeout);

  assign stall = ((state_q == S_IDLE) && w_access && w_aligned) || (state_q == S_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      fault_q           <= 1'b0;
      rdata_q           <= '0;
      mem_req_q         <= 1'b0;
      mem_we_q          <= 1'b0;
      mem_addr_q        <= '0;
      mem_wdata_q       <= '0;
      wb_regWrite_q     <= 1'b0;
      wb_memToReg_q     <= '0;
      wb_writeDataReg_q <= '0;
      wb_aluResult_q    <= '0;
      wb_memData_q      <= '0;
      wb_fourPC_q       <= '0;
      err_q             <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (w_access && w_aligned) begin
            mem_req_q         <= 1'b1;
            mem_we_q          <= memWrite;
            mem_addr_q        <= aluResult;
            mem_wdata_q       <= readData2;
            fault_q           <= 1'b0;
            wb_regWrite_q     <= 1'b0;
            wb_memToReg_q     <= '0;
            wb_writeDataReg_q <= '0;
            wb_aluResult_q    <= '0;
            wb_memData_q      <= '0;
            wb_fourPC_q       <= '0;
            state_q           <= S_BUSY;
          end else begin
            // A misaligned access falls through here and is reported, not issued.
            wb_regWrite_q     <= regWrite & ~w_access;
            wb_memToReg_q     <= memToReg;
            wb_writeDataReg_q <= writeDataReg;
            wb_aluResult_q    <= aluResult;
            wb_memData_q      <= '0;
            wb_fourPC_q       <= fourPC;
            err_q             <= w_access;
          end
        end
        S_BUSY: begin
          cnt_q <= w_cnt_inc[7:0];
          if (mem_ack) begin
            rdata_q   <= mem_rdata;
            mem_req_q <= 1'b0;
            fault_q   <= 1'b0;
            state_q   <= S_DONE;
          end else if (w_timeout) begin
            rdata_q   <= '0;
            mem_req_q <= 1'b0;
            fault_q   <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          wb_regWrite_q     <= regWrite & ~fault_q;
          wb_memToReg_q     <= memToReg;
          wb_writeDataReg_q <= writeDataReg;
          wb_aluResult_q    <= aluResult;
          wb_memData_q      <= rdata_q;
          wb_fourPC_q       <= fourPC;
          err_q             <= fault_q;
          cnt_q             <= '0;
          state_q           <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req          = mem_req_q;
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign out_regWrite     = wb_regWrite_q;
  assign out_memToReg     = wb_memToReg_q;
  assign out_writeDataReg = wb_writeDataReg_q;
  assign out_aluResult    = wb_aluResult_q;
  assign out_memData      = wb_memData_q;
  assign out_fourPC       = wb_fourPC_q;
  assign err              = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_ctrl
//  Purpose  : Self-checking bench: vector table, reset/abort sequence and
//             randomized instructions against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite, regWrite;
  logic [1:0]  memToReg;
  logic [31:0] aluResult, readData2;
  logic [4:0]  writeDataReg;
  logic [29:0] fourPC;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        out_regWrite;
  logic [1:0]  out_memToReg;
  logic [4:0]  out_writeDataReg;
  logic [31:0] out_aluResult, out_memData;
  logic [29:0] out_fourPC;
  logic        err;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
    .memToReg(memToReg), .aluResult(aluResult), .readData2(readData2),
    .writeDataReg(writeDataReg), .fourPC(fourPC),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_regWrite(out_regWrite), .out_memToReg(out_memToReg),
    .out_writeDataReg(out_writeDataReg), .out_aluResult(out_aluResult),
    .out_memData(out_memData), .out_fourPC(out_fourPC), .err(err)
  );

  typedef struct {
    logic        rd, wr, rw;
    logic [1:0]  m2r;
    logic [31:0] alu, wdata;
    logic [4:0]  dst;
    logic [29:0] pc4;
    int          ack_at;   // BUSY cycle (1-based) carrying ack; 0 = never
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          stall_cycles;
    logic        rw;
    logic [31:0] mdata;
    logic        err;
  } exp_t;

  typedef struct {
    vec_t v;
    exp_t e;
  } entry_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level reference: whole-instruction outcome from the access rules.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    bit access  = v.rd | v.wr;
    bit aligned = (v.alu % 4) == 0;
    bit acked   = (v.ack_at >= 1) && (v.ack_at <= TO);
    if (!access) begin
      e = '{0, v.rw, 32'd0, 1'b0};
    end else if (!aligned) begin
      e = '{0, 1'b0, 32'd0, 1'b1};
    end else if (acked) begin
      e = '{1 + v.ack_at, v.rw, v.rdata, 1'b0};
    end else begin
      e = '{1 + TO, 1'b0, 32'd0, 1'b1};
    end
    return e;
  endfunction

  // Presents one EX/MEM entry (called at a negedge, DUT idle), holds it while
  // stalled, acks on the requested BUSY cycle, then checks the MEM/WB result.
  task automatic run_instr(input string nm, input vec_t v, input exp_t e);
    int n_stall = 0;
    int busy    = 0;
    memRead = v.rd; memWrite = v.wr; regWrite = v.rw; memToReg = v.m2r;
    aluResult = v.alu; readData2 = v.wdata; writeDataReg = v.dst; fourPC = v.pc4;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    while (stall) begin
      n_stall++;
      if (n_stall > 40) begin
        checks++; failures++;
        $display("FAIL %s_stall_bound: stall still high after %0d cycles, required release", nm, n_stall);
        break;
      end
      @(posedge clk);
      @(negedge clk);
      busy++;
      mem_ack   = (busy == v.ack_at);
      mem_rdata = (busy == v.ack_at) ? v.rdata : $urandom;
      if (busy == 1) begin
        chk({nm, "_req"},    64'(mem_req), 64'd1);
        chk({nm, "_we"},     64'(mem_we), 64'(v.wr));
        chk({nm, "_addr"},   64'(mem_addr), 64'(v.alu));
        chk({nm, "_wdata"},  64'(mem_wdata), 64'(v.wdata));
        chk({nm, "_bubble"}, {out_regWrite, out_memToReg, out_writeDataReg,
                              out_aluResult, out_fourPC[22:0], err}, 64'd0);
      end
      #1;
    end
    chk({nm, "_stall_cycles"}, 64'(n_stall), 64'(e.stall_cycles));
    chk({nm, "_req_idle"}, 64'(mem_req), 64'd0);
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    chk({nm, "_rw"},    64'(out_regWrite), 64'(e.rw));
    chk({nm, "_m2r"},   64'(out_memToReg), 64'(v.m2r));
    chk({nm, "_dst"},   64'(out_writeDataReg), 64'(v.dst));
    chk({nm, "_alu"},   64'(out_aluResult), 64'(v.alu));
    chk({nm, "_pc4"},   64'(out_fourPC), 64'(v.pc4));
    chk({nm, "_mdata"}, 64'(out_memData), 64'(e.mdata));
    chk({nm, "_err"},   64'(err), 64'(e.err));
    chk({nm, "_no_rereq"}, 64'(mem_req), 64'd0);
  endtask

  task automatic clear_inputs();
    memRead = 0; memWrite = 0; regWrite = 0; memToReg = '0;
    aluResult = '0; readData2 = '0; writeDataReg = '0; fourPC = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_stall"}, 64'(stall), 64'd0);
    chk({nm, "_bus"}, {mem_req, mem_we, mem_addr[30:0], 1'b0} | 64'(mem_wdata), 64'd0);
    chk({nm, "_wb"}, {out_regWrite, out_memToReg, out_writeDataReg, err,
                      out_fourPC[24:0]} | 64'(out_aluResult) | 64'(out_memData), 64'd0);
  endtask

  entry_t tbl[9];
  vec_t   rv;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{'{0,0,1,2'd0,32'h10,32'hDEAD,5'd5,30'h100,0,32'h0},        '{0,1,32'h0,0}};
    tbl[1] = '{'{1,0,1,2'd1,32'h100,32'h0,5'd7,30'h101,3,32'hCAFEF00D},  '{4,1,32'hCAFEF00D,0}};
    tbl[2] = '{'{0,1,0,2'd0,32'h204,32'h12345678,5'd0,30'h102,1,32'h0},  '{2,0,32'h0,0}};
    tbl[3] = '{'{1,0,1,2'd1,32'h102,32'h0,5'd9,30'h103,0,32'h0},         '{0,0,32'h0,1}};
    tbl[4] = '{'{1,0,1,2'd1,32'h40,32'h0,5'd3,30'h104,0,32'h0},          '{5,0,32'h0,1}};
    tbl[5] = '{'{1,1,1,2'd2,32'h8,32'hA5A5,5'd4,30'h105,2,32'h77},       '{3,1,32'h77,0}};
    tbl[6] = '{'{0,1,0,2'd0,32'h3,32'h55,5'd1,30'h106,1,32'h0},          '{0,0,32'h0,1}};
    tbl[7] = '{'{1,0,1,2'd1,32'h80,32'h0,5'd6,30'h107,4,32'hBEEF},       '{5,1,32'hBEEF,0}};
    tbl[8] = '{'{1,0,1,2'd1,32'hC0,32'h0,5'd8,30'h108,5,32'h1234},       '{5,0,32'h0,1}};

    rst = 1'b1;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_instr($sformatf("vec%0d", i), tbl[i].v, tbl[i].e);

    // Reset during the second BUSY cycle aborts the access without writeback.
    memRead = 1; regWrite = 1; aluResult = 32'h300; writeDataReg = 5'd12; fourPC = 30'h200;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("abort_busy_req", 64'(mem_req), 64'd1);
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); @(negedge clk);
    chk_all_zero("abort");
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    chk_all_zero("late_ack");

    for (int n = 0; n < 150; n++) begin
      rv.rd    = 1'($urandom_range(0, 1));
      rv.wr    = ($urandom_range(0, 3) == 0);
      rv.rw    = 1'($urandom_range(0, 1));
      rv.m2r   = 2'($urandom_range(0, 3));
      rv.alu   = $urandom;
      if ($urandom_range(0, 2) != 0) rv.alu[1:0] = 2'b00;
      rv.wdata = $urandom;
      rv.dst   = 5'($urandom);
      rv.pc4   = 30'($urandom);
      rv.ack_at = $urandom_range(0, 6);
      rv.rdata = $urandom;
      run_instr($sformatf("rnd%0d", n), rv, model(rv));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
